lcd_cmd_seq: RTL and testbench

LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

---
 rtl/lcd_cmd_seq.sv | 196 +++++++++++++++++++
 tb/tb_lcd_cmd_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : lcd_cmd_seq
// Description : Plays a script of LCD controller opcodes stored in an external
//               command ROM. Each entry is fetched and latched. It is issued
//               once the controller is idle. The block then waits for the
//               controller to accept the command (busy rises) and to finish
//               it (busy falls). A set end-marker bit, or the last ROM
//               address, ends the run.
// Revision    : 1.0 - initial release
//
// Optional feature macro: LCD_SEQ_TIMEOUT_EN
//   When defined, a watchdog counts cycles spent in WAIT_ACK / WAIT_DONE.
//   On reaching TO_LIMIT it sets the sticky to_err flag and ends the run.
//   When undefined, to_err is tied low and the wait states wait forever.
//
// Parameters
//   CMD_AW    : command ROM address width (2**CMD_AW entries)
//   TO_LIMIT  : watchdog limit in cycles (only with LCD_SEQ_TIMEOUT_EN)
//
// Ports
//   clk        in   clock, rising-edge active
//   reset      in   synchronous active-high reset
//   start      in   one-cycle pulse, starts a run from entry 0
//   CMDROM_rd  out  command ROM read enable
//   CMDROM_A   out  command ROM address
//   CMDROM_Q   in   ROM data, valid the cycle after CMDROM_rd
//                   ([4] = end marker, [3:0] = opcode)
//   cmd        out  opcode presented to the LCD controller
//   cmd_valid  out  one-cycle command strobe
//   busy       in   LCD controller busy flag
//   seq_done   out  script finished, held until next start or reset
//   cmd_cnt    out  commands completed in the current run (saturating)
//   to_err     out  watchdog fired (sticky)
// ============================================================================
module lcd_cmd_seq #(
  parameter int CMD_AW   = 5,
  parameter int TO_LIMIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              CMDROM_rd,
  output logic [CMD_AW-1:0] CMDROM_A,
  input  logic [4:0]        CMDROM_Q,
  output logic [3:0]        cmd,
  output logic              cmd_valid,
  input  logic              busy,
  output logic              seq_done,
  output logic [CMD_AW:0]   cmd_cnt,
  output logic              to_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_LATCH     = 3'd2;
  localparam logic [2:0] S_WAIT_IDLE = 3'd3;
  localparam logic [2:0] S_ISSUE     = 3'd4;
  localparam logic [2:0] S_WAIT_ACK  = 3'd5;
  localparam logic [2:0] S_WAIT_DONE = 3'd6;
  localparam logic [2:0] S_FINISH    = 3'd7;

  localparam logic [CMD_AW-1:0] c_ADDR_LAST = '1;
  // A run can complete at most 2**CMD_AW commands, so that is the ceiling.
  localparam logic [CMD_AW:0]   c_CNT_MAX   = {1'b1, {CMD_AW{1'b0}}};

  logic [2:0]        r_state;
  logic [CMD_AW-1:0] r_addr;
  logic [3:0]        r_cmd;
  logic [CMD_AW:0]   r_cnt;
  logic              w_to_fire;

`ifdef LCD_SEQ_TIMEOUT_EN
  localparam int            c_TO_W    = (TO_LIMIT < 2) ? 1 : $clog2(TO_LIMIT + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TO_LIMIT - 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_to_err;
  logic              w_waiting;

  // Still waiting means the FSM stays in a wait state this cycle. Any exit,
  // including the timeout itself, restarts the count from zero.
  assign w_waiting = ((r_state == S_WAIT_ACK)  && !busy) ||
                     ((r_state == S_WAIT_DONE) &&  busy);
  // Fires on the TO_LIMIT-th consecutive cycle spent waiting.
  assign w_to_fire = w_waiting && (r_to_cnt == c_TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      if (w_waiting && !w_to_fire) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
      if ((r_state == S_IDLE) && start) begin
        r_to_err <= 1'b0;
      end else if (w_to_fire) begin
        r_to_err <= 1'b1;
      end
    end
  end

  assign to_err = r_to_err;
`else
  logic w_unused_to_limit;

  // The watchdog limit only matters when the watchdog is built in.
  assign w_unused_to_limit = (TO_LIMIT == 0);
  assign w_to_fire         = 1'b0;
  assign to_err            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cmd   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= '0;
            r_cnt   <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          // ROM data is valid now, one cycle after the read strobe.
          if (CMDROM_Q[4]) begin
            r_state <= S_FINISH;
          end else begin
            r_cmd   <= CMDROM_Q[3:0];
            r_state <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (!busy) begin
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (busy) begin
            r_state <= S_WAIT_DONE;
          end else if (w_to_fire) begin
            r_state <= S_FINISH;
          end
        end
        S_WAIT_DONE: begin
          if (!busy) begin
            if (r_cnt != c_CNT_MAX) begin
              r_cnt <= r_cnt + 1'b1;
            end
            // The last ROM entry ends the run. The address never wraps.
            if (r_addr == c_ADDR_LAST) begin
              r_state <= S_FINISH;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_state <= S_FETCH;
            end
          end else if (w_to_fire) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          if (start) begin
            r_addr  <= '0;
            r_cnt   <= '0;
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign CMDROM_rd = (r_state == S_FETCH);
  assign CMDROM_A  = r_addr;
  assign cmd       = r_cmd;
  assign cmd_valid = (r_state == S_ISSUE);
  assign seq_done  = (r_state == S_FINISH);
  assign cmd_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_cmd_seq
// Description : Self-checking bench for lcd_cmd_seq (default build). A table
//               of short scripts is played back-to-back. Hand sequences then
//               cover busy held high, start ignored mid-run, a full ROM with
//               no end marker, and a reset during WAIT_DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_cmd_seq;

  localparam int CMD_AW = 5;

  logic              clk;
  logic              reset;
  logic              start;
  logic              CMDROM_rd;
  logic [CMD_AW-1:0] CMDROM_A;
  logic [4:0]        CMDROM_Q;
  logic [3:0]        cmd;
  logic              cmd_valid;
  logic              busy;
  logic              seq_done;
  logic [CMD_AW:0]   cmd_cnt;
  logic              to_err;

  lcd_cmd_seq #(.CMD_AW(CMD_AW), .TO_LIMIT(255)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .CMDROM_rd (CMDROM_rd),
    .CMDROM_A  (CMDROM_A),
    .CMDROM_Q  (CMDROM_Q),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .busy      (busy),
    .seq_done  (seq_done),
    .cmd_cnt   (cmd_cnt),
    .to_err    (to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Command ROM model: registered read, data valid the cycle after rd.
  logic [4:0] rom_mem [0:31];
  always @(posedge clk) begin
    if (CMDROM_rd) CMDROM_Q <= rom_mem[CMDROM_A];
  end

  // Controller model: busy rises right after a strobe and stays high for
  // busy_len cycles. busy_force holds it high regardless.
  int   busy_len;
  int   busy_ctr;
  logic busy_force;
  initial busy_ctr = 0;
  always @(negedge clk) begin
    if (cmd_valid) busy_ctr = busy_len;
    else if (busy_ctr > 0) busy_ctr = busy_ctr - 1;
  end
  assign busy = busy_force | (busy_ctr != 0);

  // Strobe monitor: records every issued opcode.
  logic [3:0] got_mem [0:511];
  int         pulse_cnt;
  initial pulse_cnt = 0;
  always @(negedge clk) begin
    if (cmd_valid && pulse_cnt < 512) begin
      got_mem[pulse_cnt] = cmd;
      pulse_cnt = pulse_cnt + 1;
    end
  end

  int n_chk;
  int n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int c;
    for (c = 0; c < budget; c++) begin
      if (seq_done) break;
      tick();
    end
    chk({nm, " done_in_time"}, {31'd0, seq_done}, 32'd1);
  endtask

  typedef struct {
    logic [4:0][3:0] ops;     // ops[0] is ROM entry 0
    int              n;       // commands before the end marker
    int              blen;    // busy cycles per command
    int              exp_cnt; // expected cmd_cnt after the run
  } vec_t;

  vec_t vecs [0:3];

  initial begin
    int base;
    n_chk      = 0;
    n_err      = 0;
    start      = 1'b0;
    reset      = 1'b1;
    busy_force = 1'b0;
    busy_len   = 2;
    for (int j = 0; j < 32; j++) rom_mem[j] = 5'h10;

    // {entry4, entry3, entry2, entry1, entry0}
    vecs[0].ops = {4'h0, 4'h0, 4'h0, 4'h4, 4'h1}; vecs[0].n = 2; vecs[0].blen = 5; vecs[0].exp_cnt = 2;
    vecs[1].ops = {4'h0, 4'h0, 4'h0, 4'h0, 4'h0}; vecs[1].n = 0; vecs[1].blen = 3; vecs[1].exp_cnt = 0;
    vecs[2].ops = {4'h0, 4'h0, 4'h8, 4'hF, 4'h0}; vecs[2].n = 3; vecs[2].blen = 2; vecs[2].exp_cnt = 3;
    vecs[3].ops = {4'h0, 4'hC, 4'h3, 4'h5, 4'hA}; vecs[3].n = 4; vecs[3].blen = 3; vecs[3].exp_cnt = 4;

    repeat (3) tick();
    chk("rst cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst CMDROM_rd", {31'd0, CMDROM_rd}, 32'd0);
    chk("rst CMDROM_A",  {27'd0, CMDROM_A},  32'd0);
    chk("rst cmd",       {28'd0, cmd},       32'd0);
    chk("rst seq_done",  {31'd0, seq_done},  32'd0);
    chk("rst cmd_cnt",   {26'd0, cmd_cnt},   32'd0);
    chk("rst to_err",    {31'd0, to_err},    32'd0);
    reset = 1'b0;
    tick();

    // Scripts back-to-back: first start from IDLE, the rest from FINISH.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 32; j++) rom_mem[j] = 5'h10;
      for (int j = 0; j < vecs[i].n; j++) rom_mem[j] = {1'b0, vecs[i].ops[j]};
      busy_len = vecs[i].blen;
      base     = pulse_cnt;
      pulse_start();
      chk($sformatf("v%0d seq_done_cleared", i), {31'd0, seq_done}, 32'd0);
      wait_done($sformatf("v%0d", i), 500);
      chk($sformatf("v%0d pulses", i), pulse_cnt - base, vecs[i].n);
      for (int j = 0; j < vecs[i].n; j++)
        chk($sformatf("v%0d op%0d", i, j), {28'd0, got_mem[base + j]}, {28'd0, vecs[i].ops[j]});
      chk($sformatf("v%0d cmd_cnt", i), {26'd0, cmd_cnt}, vecs[i].exp_cnt);
      chk($sformatf("v%0d to_err", i), {31'd0, to_err}, 32'd0);
    end

    // Busy held high after start; a start during WAIT_IDLE is ignored.
    for (int j = 0; j < 32; j++) rom_mem[j] = 5'h10;
    rom_mem[0] = 5'h03;
    busy_len   = 2;
    busy_force = 1'b1;
    base       = pulse_cnt;
    pulse_start();
    repeat (4) tick();
    pulse_start();
    repeat (14) tick();
    chk("hold no_strobe",  pulse_cnt - base,   32'd0);
    chk("hold CMDROM_A",   {27'd0, CMDROM_A},  32'd0);
    chk("hold cmd_cnt",    {26'd0, cmd_cnt},   32'd0);
    chk("hold cmd",        {28'd0, cmd},       32'd3);
    chk("hold CMDROM_rd",  {31'd0, CMDROM_rd}, 32'd0);
    busy_force = 1'b0;
    tick();
    chk("hold strobe_now", {31'd0, cmd_valid}, 32'd1);
    wait_done("hold", 200);
    chk("hold pulses",     pulse_cnt - base,   32'd1);
    chk("hold op",         {28'd0, got_mem[base]}, 32'd3);
    chk("hold cnt_end",    {26'd0, cmd_cnt},   32'd1);

    // Full ROM of opcode 7, no end marker: stops at the last address.
    for (int j = 0; j < 32; j++) rom_mem[j] = 5'h07;
    busy_len = 2;
    base     = pulse_cnt;
    pulse_start();
    wait_done("full", 2000);
    chk("full pulses",   pulse_cnt - base,  32'd32);
    begin
      int bad;
      bad = 0;
      for (int j = 0; j < 32; j++) if (got_mem[base + j] !== 4'h7) bad++;
      chk("full ops_bad", bad, 32'd0);
    end
    chk("full cmd_cnt",  {26'd0, cmd_cnt},  32'd32);
    chk("full CMDROM_A", {27'd0, CMDROM_A}, 32'd31);

    // Reset during WAIT_DONE of the second command, then a clean rerun.
    for (int j = 0; j < 32; j++) rom_mem[j] = 5'h10;
    rom_mem[0] = 5'h02;
    rom_mem[1] = 5'h06;
    rom_mem[2] = 5'h09;
    busy_len   = 6;
    base       = pulse_cnt;
    pulse_start();
    begin
      int c;
      for (c = 0; c < 200; c++) begin
        if (pulse_cnt - base >= 2) break;
        tick();
      end
      chk("rr second_strobe", pulse_cnt - base, 32'd2);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rr CMDROM_rd", {31'd0, CMDROM_rd}, 32'd0);
    chk("rr CMDROM_A",  {27'd0, CMDROM_A},  32'd0);
    chk("rr cmd",       {28'd0, cmd},       32'd0);
    chk("rr seq_done",  {31'd0, seq_done},  32'd0);
    chk("rr cmd_cnt",   {26'd0, cmd_cnt},   32'd0);
    chk("rr to_err",    {31'd0, to_err},    32'd0);
    repeat (10) tick();
    chk("rr no_strobe_after", pulse_cnt - base, 32'd2);
    base = pulse_cnt;
    pulse_start();
    wait_done("rr rerun", 500);
    chk("rr rerun pulses", pulse_cnt - base, 32'd3);
    chk("rr rerun op0", {28'd0, got_mem[base]},     32'd2);
    chk("rr rerun op1", {28'd0, got_mem[base + 1]}, 32'd6);
    chk("rr rerun op2", {28'd0, got_mem[base + 2]}, 32'd9);
    chk("rr rerun cmd_cnt", {26'd0, cmd_cnt}, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
